csa_word_sequencer: RTL and testbench
=====================================

// Module: csa_word_sequencer
// PURPOSE
//   Multi-cycle word adder built on one shared 4-bit carry-select slice.
//   Each slice has two precomputed 4-bit sums, one for carry-in 0 and one for carry-in 1.
//   A registered carry chooses between them, one nibble per clock, LSB first.
//   Sits between an operand producer and a result consumer, with valid/ready on both sides.
// PARAMETERS
//   WIDTH   16   operand/sum width; must be a multiple of 4 and >= 4 (elaboration error otherwise)
//   NSLICE  WIDTH/4   derived localparam; nibbles per operation
// PORTS
//   clk        in   1      rising-edge clock; single clock domain
//   rst_n      in   1      reset, synchronous, active-low
//   in_valid   in   1      operand request
//   in_ready   out  1      block can accept operands
//   a          in   WIDTH  operand A, sampled on accept
//   b          in   WIDTH  operand B, sampled on accept
//   cin        in   1      carry-in, sampled on accept
//   out_valid  out  1      result available
//   out_ready  in   1      consumer takes result
//   sum        out  WIDTH  result word
//   cout       out  1      final carry-out
//   busy       out  1      high in RUN or DONE
// BEHAVIOUR
//   Reset (rst_n==0 at posedge):
//     - state=IDLE; sum=0, cout=0, out_valid=0, busy=0; internal carry/index=0.
//     - in_ready=1 from the first cycle after reset.
//   FSM states: IDLE, RUN, DONE.
//   IDLE:
//     - in_ready=1.
//     - On in_valid&&in_ready: capture a, b and carry<=cin; idx<=0; clear sum; go to RUN.
//   RUN (in_ready=0):
//     - Per cycle, slice idx computes s0=a_n+b_n+0 and s1=a_n+b_n+1, 5 bits each.
//     - sum[4*idx+:4] <= carry ? s1[3:0] : s0[3:0].
//     - carry <= carry ? s1[4] : s0[4].
//     - idx increments; after idx==NSLICE-1, go to DONE and set cout=final carry.
//   DONE:
//     - out_valid=1; sum/cout held stable until out_ready.
//     - On out_valid&&out_ready: out_valid<=0, go to IDLE.
//     - in_ready stays 0 in DONE; a new accept is possible the cycle after handoff.
//   Timing:
//     - Accept at edge k; out_valid=1 after edge k+NSLICE.
//     - Throughput: at most one operation per NSLICE+2 cycles.
//   Arithmetic:
//     - Modulo 2^WIDTH; cout is bit WIDTH of a+b+cin.
//     - The index counter never wraps past NSLICE-1.
//   Boundaries:
//     - in_valid while busy is ignored; no capture and no queuing.
//     - out_ready low stalls indefinitely with no data change.
//     - rst_n low mid-RUN or mid-DONE aborts the operation; the result is discarded and outputs return to reset values.
//     - Operand inputs may change freely after accept.
// CONFIGURATION
//   CSA_SUB_EN defined:
//     - Adds input sub (1) and output ovf (1).
//     - When sub=1 at accept: B is captured inverted and carry<=1 (cin ignored), so the result is A-B.
//     - ovf = signed overflow of the final op, valid with out_valid; reset 0.
//     - cout=1 means no borrow.
//   CSA_SUB_EN undefined:
//     - No sub/ovf ports; add only.
// TESTING (WIDTH=16)
//   1. a=0x1234, b=0x4321, cin=0 -> out_valid 4 cycles after accept; sum=0x5555, cout=0.
//   2. a=0xFFFF, b=0x0001, cin=0 -> carry ripples through all slices; sum=0x0000, cout=1.
//   3. a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1; a=0, b=0, cin=1 -> sum=0x0001, cout=0.
//   4. Result with out_ready held 0 for 6 cycles -> out_valid, sum and cout stable; in_ready=0; in_valid pulses ignored.
//   5. rst_n=0 during RUN (idx=2) -> next cycle sum=0, out_valid=0, busy=0, in_ready=1; a fresh op completes correctly.
//   6. CSA_SUB_EN, sub=1:
//      - 5-7 -> sum=0xFFFE, cout=0, ovf=0.
//      - 0x8000-1 -> sum=0x7FFF, cout=1, ovf=1.

Source files
------------

// File: rtl/csa_word_sequencer_if.sv
// rtl/csa_word_sequencer_if.sv - operand/result handshake bundle for csa_word_sequencer
//
// Purpose : groups the operand-side and result-side valid/ready handshakes
//           together with the data words and the busy status.
// Modports: slave  - the adder block (consumes operands, produces result)
//           master - the producer/consumer driving operands and taking results
// Signals : in_valid/in_ready, a, b, cin   operand handshake and data
//           out_valid/out_ready, sum, cout result handshake and data
//           busy                           block is in RUN or DONE
//           sub/ovf                        only with CSA_SUB_EN defined
// Config  : CSA_SUB_EN adds the sub request and signed-overflow flag.
interface csa_word_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
`ifdef CSA_SUB_EN
    logic             sub;
    logic             ovf;

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, busy
    );
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, busy
    );
`else
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );
`endif
endinterface

// File: rtl/csa_word_sequencer.sv
// rtl/csa_word_sequencer.sv - multi-cycle word adder on one shared 4-bit carry-select slice
//
// Purpose : adds two WIDTH-bit operands one nibble per clock, LSB first.
//           The slice precomputes nibble sums for carry-in 0 and 1 and the
//           registered carry picks one, so a word takes WIDTH/4 cycles.
// Ports   : clk    rising-edge clock
//           rst_n  synchronous active-low reset
//           bus    csa_word_sequencer_if.slave (operand and result handshakes,
//                  a, b, cin, sum, cout, busy; sub/ovf with CSA_SUB_EN)
// Config  : CSA_SUB_EN - when defined, sub=1 at accept computes A-B
//           (B inverted, carry forced to 1) and ovf reports signed overflow.
module csa_word_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    csa_word_sequencer_if.slave  bus
);
    localparam int NSLICE = WIDTH / 4;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    generate
        if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
            $error("csa_word_sequencer: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic             carry_q, cout_q;
    logic [IDXW-1:0]  idx_q;
`ifdef CSA_SUB_EN
    logic             ovf_q;
`endif

    logic             in_ready_w, out_valid_w, busy_w;
    logic             accept, handoff, last;
    logic [3:0]       a_n, b_n, nib_sum;
    logic [4:0]       s0, s1;
    logic             nib_carry;

    assign accept  = bus.in_valid && in_ready_w;
    assign handoff = out_valid_w && bus.out_ready;
    assign last    = (idx_q == IDXW'(NSLICE - 1));

    // Carry-select slice: both candidate sums exist before the carry is known.
    always_comb begin
        a_n = 4'd0;
        b_n = 4'd0;
        for (int i = 0; i < NSLICE; i++) begin
            if (idx_q == IDXW'(i)) begin
                a_n = a_q[4*i +: 4];
                b_n = b_q[4*i +: 4];
            end
        end
        s0        = {1'b0, a_n} + {1'b0, b_n};
        s1        = s0 + 5'd1;
        nib_sum   = carry_q ? s1[3:0] : s0[3:0];
        nib_carry = carry_q ? s1[4]   : s0[4];
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)  state_d = RUN;
            RUN:     if (last)    state_d = DONE;
            DONE:    if (handoff) state_d = IDLE;
            default:              state_d = IDLE;
        endcase
    end

    // Outputs decoded from the registered state
    always_comb begin
        in_ready_w  = (state_q == IDLE);
        out_valid_w = (state_q == DONE);
        busy_w      = (state_q == RUN) || (state_q == DONE);
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
`ifdef CSA_SUB_EN
            ovf_q   <= 1'b0;
`endif
        end else if (accept) begin
            a_q   <= bus.a;
            idx_q <= '0;
            sum_q <= '0;
`ifdef CSA_SUB_EN
            // A-B as A + ~B + 1; the caller's cin has no meaning here.
            b_q     <= bus.sub ? ~bus.b : bus.b;
            carry_q <= bus.sub ? 1'b1   : bus.cin;
            ovf_q   <= 1'b0;
`else
            b_q     <= bus.b;
            carry_q <= bus.cin;
`endif
        end else if (state_q == RUN) begin
            for (int i = 0; i < NSLICE; i++) begin
                if (idx_q == IDXW'(i)) begin
                    sum_q[4*i +: 4] <= nib_sum;
                end
            end
            carry_q <= nib_carry;
            if (last) begin
                cout_q <= nib_carry;
`ifdef CSA_SUB_EN
                // Overflow: operand signs agree but the result sign differs.
                ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (nib_sum[3] != a_q[WIDTH-1]);
`endif
            end else begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_w;
    assign bus.busy      = busy_w;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
`ifdef CSA_SUB_EN
    assign bus.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_csa_word_sequencer.sv
// tb/tb_csa_word_sequencer.sv - directed self-checking bench for csa_word_sequencer
module tb_csa_word_sequencer;
    localparam int WIDTH = 16;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    csa_word_sequencer_if #(.WIDTH(WIDTH)) bus ();

    csa_word_sequencer #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive operands at a falling edge, hold through one rising edge, then scramble them.
    task automatic start_op(input logic [15:0] av, input logic [15:0] bv, input logic c, input logic s);
        bus.in_valid = 1'b1;
        bus.a        = av;
        bus.b        = bv;
        bus.cin      = c;
`ifdef CSA_SUB_EN
        bus.sub      = s;
`else
        if (s) $error("FAIL sub_request observed=1 expected=0");
`endif
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a        = 16'($urandom);
        bus.b        = 16'($urandom);
        bus.cin      = 1'($urandom);
`ifdef CSA_SUB_EN
        bus.sub      = 1'($urandom);
`endif
    endtask

    task automatic wait_result(input string tag);
        int lat;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd4);
    endtask

    task automatic check_result(input string tag, input logic [15:0] es, input logic ec, input logic eo);
        check({tag, "_sum"},  32'(bus.sum),  32'(es));
        check({tag, "_cout"}, 32'(bus.cout), 32'(ec));
`ifdef CSA_SUB_EN
        check({tag, "_ovf"},  32'(bus.ovf),  32'(eo));
`else
        if (eo === 1'bx) $error("FAIL %s_ovf observed=x expected=0", tag);
`endif
    endtask

    task automatic handoff(input string tag);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, "_out_valid_after"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_in_ready_after"},  32'(bus.in_ready),  32'd1);
    endtask

    task automatic do_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                         input logic c, input logic s,
                         input logic [15:0] es, input logic ec, input logic eo);
        start_op(av, bv, c, s);
        check({tag, "_busy"},     32'(bus.busy),     32'd1);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
        wait_result(tag);
        check_result(tag, es, ec, eo);
        handoff(tag);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b0;
`ifdef CSA_SUB_EN
        bus.sub       = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy",      32'(bus.busy),      32'd0);
        check("rst_sum",       32'(bus.sum),       32'd0);
        check("rst_cout",      32'(bus.cout),      32'd0);

        // Plain additions
        do_op("add_basic",  16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        do_op("add_ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_op("add_cin_ff", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_op("add_cin_0",  16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0);
        do_op("add_msb",    16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        do_op("add_mixed",  16'hABCD, 16'h1111, 1'b1, 1'b0, 16'hBCDF, 1'b0, 1'b0);

        // Consumer stall with ignored operand requests
        start_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        wait_result("stall");
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = (i % 2 == 0);
            bus.a        = 16'h0F0F;
            bus.b        = 16'h0101;
            @(negedge clk);
            check("stall_out_valid", 32'(bus.out_valid), 32'd1);
            check("stall_in_ready",  32'(bus.in_ready),  32'd0);
            check_result("stall", 16'h8000, 1'b0, 1'b1);
        end
        bus.in_valid = 1'b0;
        handoff("stall");
        check("stall_idle_busy", 32'(bus.busy), 32'd0);

        // Abort in the middle of RUN (idx==2)
        start_op(16'hAAAA, 16'h5555, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_sum",       32'(bus.sum),       32'd0);
        check("abort_cout",      32'(bus.cout),      32'd0);
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_busy",      32'(bus.busy),      32'd0);
        check("abort_in_ready",  32'(bus.in_ready),  32'd1);
        do_op("post_abort", 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);

`ifdef CSA_SUB_EN
        do_op("sub_neg",  16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        do_op("sub_ovf",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
